// File: rtl/seg7_pkg.sv
// Shared types and segment patterns for the 7-segment scan controller.
// Patterns are active-high {g,f,e,d,c,b,a}; polarity is applied at the pins.
package seg7_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  localparam logic [6:0] SEG_LUT [16] = '{
    7'b0111111, // 0
    7'b0000110, // 1
    7'b1011011, // 2
    7'b1001111, // 3
    7'b1100110, // 4
    7'b1101101, // 5
    7'b1111101, // 6
    7'b0000111, // 7
    7'b1111111, // 8
    7'b1101111, // 9
    7'b1110111, // A
    7'b1111100, // b
    7'b0111001, // C
    7'b1011110, // d
    7'b1111001, // E
    7'b1110001  // F
  };

  function automatic logic [6:0] hex_to_seg(
    input logic [3:0] nib
  );
    return SEG_LUT[nib];
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Hex nibble to active-high 7-segment pattern.
// Purely combinational; one instance sits on the muxed digit nibble.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  // table lookup through the shared helper
  always_comb begin
    seg_o = hex_to_seg(nib_i);
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode N-digit display.
// Double-buffered value, blank gap between digits, leading-zero blanking.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int DWELL_TICKS    = 1,
  parameter int BLANK_CYCLES   = 270,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  tick_i,
  input  logic [4*N_DIGITS-1:0] value_i,
  input  logic                  load_i,
  input  logic                  blank_lz_i,
  output logic                  load_ack_o,
  output logic                  frame_o,
  output logic [N_DIGITS-1:0]   an_o,
  output logic [6:0]            seg_o
);

  localparam int IW = $clog2(N_DIGITS);
  localparam int BW =
    (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam int DW =
    (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;

  localparam logic [IW-1:0] IDX_LAST =
    IW'(N_DIGITS - 1);
  localparam logic [BW-1:0] BLK_LAST =
    BW'(BLANK_CYCLES - 1);
  localparam logic [DW-1:0] DWL_LAST =
    DW'(DWELL_TICKS - 1);

  localparam logic [N_DIGITS-1:0] AN_OFF =
    {N_DIGITS{AN_ACTIVE_LOW}};
  localparam logic [6:0] SEG_OFF =
    {7{SEG_ACTIVE_LOW}};

  scan_state_t state_q, state_d;

  logic [IW-1:0] idx_q, idx_d;
  logic [BW-1:0] blk_q, blk_d;
  logic [DW-1:0] dwl_q, dwl_d;

  logic [N_DIGITS-1:0] an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                frame_q, frame_d;
  logic                ack_q, ack_d;

  logic [4*N_DIGITS-1:0] shadow_q;
  logic [4*N_DIGITS-1:0] active_q;
  logic                  pending_q;
  logic                  commit;

  logic [3:0]          nib;
  logic [6:0]          seg_pat;
  logic [N_DIGITS-1:0] sel;
  logic                hide;
  logic                run_zero;

  // pick the current digit's nibble and anode
  always_comb begin
    nib = '0;
    sel = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        nib    = active_q[4*k +: 4];
        sel[k] = 1'b1;
      end
    end
  end

  // suppress digit k>=1 when it and all digits above are zero
  always_comb begin
    hide     = 1'b0;
    run_zero = 1'b1;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      run_zero = run_zero &
                 (active_q[4*k +: 4] == 4'h0);
      if (idx_q == IW'(k) && k != 0) begin
        hide = blank_lz_i & run_zero;
      end
    end
  end

  seg7_decoder u_dec (
    .nib_i (nib),
    .seg_o (seg_pat)
  );

  // scan state register
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= BLANK;
      idx_q   <= '0;
      blk_q   <= '0;
      dwl_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      blk_q   <= blk_d;
      dwl_q   <= dwl_d;
    end
  end

  // next state and next registered pin values
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    blk_d   = blk_q;
    dwl_d   = dwl_q;
    an_d    = an_q;
    seg_d   = seg_q;
    frame_d = 1'b0;
    ack_d   = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      BLANK: begin
        if (blk_q == BLK_LAST) begin
          blk_d   = '0;
          state_d = DRIVE;
          an_d    = hide ? AN_OFF : (AN_OFF ^ sel);
          seg_d   = hide ? SEG_OFF : (seg_pat ^ SEG_OFF);
        end else begin
          blk_d = blk_q + 1'b1;
        end
      end
      DRIVE: begin
        if (tick_i) begin
          if (dwl_q == DWL_LAST) begin
            dwl_d   = '0;
            state_d = BLANK;
            an_d    = AN_OFF;
            seg_d   = SEG_OFF;
            if (idx_q == IDX_LAST) begin
              idx_d   = '0;
              frame_d = 1'b1;
              commit  = pending_q;
              ack_d   = pending_q;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            dwl_d = dwl_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = BLANK;
      end
    endcase
  end

  // registered outputs
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      an_q    <= AN_OFF;
      seg_q   <= SEG_OFF;
      frame_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      an_q    <= an_d;
      seg_q   <= seg_d;
      frame_q <= frame_d;
      ack_q   <= ack_d;
    end
  end

  // shadow/active double buffer; a boundary load waits a frame
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      if (commit) begin
        active_q <= shadow_q;
      end
      if (load_i) begin
        shadow_q  <= value_i;
        pending_q <= 1'b1;
      end else if (commit) begin
        pending_q <= 1'b0;
      end
    end
  end

  assign an_o       = an_q;
  assign seg_o      = seg_q;
  assign frame_o    = frame_q;
  assign load_ack_o = ack_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: 4 digits, 3 blank cycles.
// Stimulus queues expected slots/frames; a monitor pops and compares.
module tb_seg7_scan_ctrl;

  localparam logic [6:0] S0  = 7'b1000000;
  localparam logic [6:0] S1  = 7'b1111001;
  localparam logic [6:0] S2  = 7'b0100100;
  localparam logic [6:0] S3  = 7'b0110000;
  localparam logic [6:0] S4  = 7'b0011001;
  localparam logic [6:0] S5  = 7'b0010010;
  localparam logic [6:0] S7  = 7'b1111000;
  localparam logic [6:0] SA  = 7'b0001000;
  localparam logic [6:0] SF  = 7'b0001110;
  localparam logic [6:0] OFF = 7'b1111111;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        tick_i = 1'b0;
  logic [15:0] value_i = '0;
  logic        load_i = 1'b0;
  logic        blank_lz_i = 1'b0;
  logic        load_ack_o;
  logic        frame_o;
  logic [3:0]  an_o;
  logic [6:0]  seg_o;

  bit          slot_tick = 1'b0;
  int          checks = 0;
  int          errors = 0;

  logic [10:0] exp_slot [$];
  bit          exp_frame [$];

  seg7_scan_ctrl #(
    .N_DIGITS       (4),
    .DWELL_TICKS    (1),
    .BLANK_CYCLES   (3),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .tick_i     (tick_i),
    .value_i    (value_i),
    .load_i     (load_i),
    .blank_lz_i (blank_lz_i),
    .load_ack_o (load_ack_o),
    .frame_o    (frame_o),
    .an_o       (an_o),
    .seg_o      (seg_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // monitor: slot contents at each pacing tick, ack at each frame
  always @(negedge clk) begin
    if (n_reset) begin
      if (slot_tick) begin
        if (exp_slot.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL slot_unexpected an=%b", an_o);
        end else begin
          logic [10:0] e;
          e = exp_slot.pop_front();
          chk("slot_an", 32'(an_o), 32'(e[10:7]));
          chk("slot_seg", 32'(seg_o), 32'(e[6:0]));
        end
      end
      if (frame_o) begin
        if (exp_frame.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame_unexpected got=1 want=0");
        end else begin
          bit ea;
          ea = exp_frame.pop_front();
          chk("frame_ack", 32'(load_ack_o), 32'(ea));
        end
      end else if (load_ack_o) begin
        checks++;
        errors++;
        $display("FAIL ack_no_frame got=1 want=0");
      end
    end
  end

  task automatic do_load(input logic [15:0] v);
    @(posedge clk); #1;
    load_i  = 1'b1;
    value_i = v;
    @(posedge clk); #1;
    load_i  = 1'b0;
  endtask

  task automatic slot(input logic [3:0] ea,
                      input logic [6:0] es,
                      input bit last,
                      input bit eack,
                      input bit ld,
                      input logic [15:0] lv);
    repeat (18) @(posedge clk);
    #1;
    exp_slot.push_back({ea, es});
    if (last) exp_frame.push_back(eack);
    tick_i    = 1'b1;
    slot_tick = 1'b1;
    if (ld) begin
      load_i  = 1'b1;
      value_i = lv;
    end
    @(posedge clk); #1;
    tick_i    = 1'b0;
    slot_tick = 1'b0;
    load_i    = 1'b0;
  endtask

  task automatic frame(input logic [6:0] s3, s2, s1, s0,
                       input logic [3:0] sh,
                       input bit eack,
                       input bit ldb,
                       input logic [15:0] lvb);
    logic [6:0] s [4];
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    for (int k = 0; k < 4; k++) begin
      logic [3:0] a;
      logic [6:0] g;
      a = sh[k] ? ~(4'b0001 << k) : 4'b1111;
      g = sh[k] ? s[k] : OFF;
      slot(a, g, k == 3, eack, (k == 3) && ldb, lvb);
    end
  endtask

  task automatic blank_len(input int en,
                           input logic [3:0] ea,
                           input logic [6:0] es);
    int n;
    n = 0;
    @(negedge clk);
    while (an_o == 4'b1111 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("blank_len", 32'(n), 32'(en));
    chk("first_an", 32'(an_o), 32'(ea));
    chk("first_seg", 32'(seg_o), 32'(es));
  endtask

  initial begin
    int bad;
    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", 32'(an_o), 32'hF);
    chk("rst_seg", 32'(seg_o), 32'h7F);
    chk("rst_ack", 32'(load_ack_o), 0);
    chk("rst_frame", 32'(frame_o), 0);
    n_reset = 1'b1;
    blank_len(3, 4'b1110, S0);

    // reset mid-DRIVE with a pending load
    do_load(16'h9999);
    repeat (3) @(posedge clk);
    #1 n_reset = 1'b0;
    #1;
    chk("mid_rst_an", 32'(an_o), 32'hF);
    chk("mid_rst_seg", 32'(seg_o), 32'h7F);
    repeat (2) @(posedge clk);
    #1 n_reset = 1'b1;
    blank_len(3, 4'b1110, S0);
    frame(S0, S0, S0, S0, 4'hF, 1'b0, 1'b0, '0);

    // scan order with 0x1234
    do_load(16'h1234);
    frame(S0, S0, S0, S0, 4'hF, 1'b1, 1'b0, '0);
    blank_len(3, 4'b1110, S4);
    frame(S1, S2, S3, S4, 4'hF, 1'b0, 1'b0, '0);

    // two loads in one frame, one ack
    do_load(16'h1111);
    repeat (4) @(posedge clk);
    do_load(16'h2222);
    frame(S1, S2, S3, S4, 4'hF, 1'b1, 1'b0, '0);
    frame(S2, S2, S2, S2, 4'hF, 1'b0, 1'b0, '0);

    // load on the boundary cycle is deferred
    frame(S2, S2, S2, S2, 4'hF, 1'b0, 1'b1, 16'h00AF);
    frame(S2, S2, S2, S2, 4'hF, 1'b1, 1'b0, '0);
    frame(S0, S0, SA, SF, 4'hF, 1'b0, 1'b0, '0);

    // boundary load while pending commits the older shadow
    do_load(16'h5555);
    frame(S0, S0, SA, SF, 4'hF, 1'b1, 1'b1, 16'h0007);
    frame(S5, S5, S5, S5, 4'hF, 1'b1, 1'b0, '0);

    // leading-zero blanking
    blank_lz_i = 1'b1;
    frame(OFF, OFF, OFF, S7, 4'b0001, 1'b0, 1'b0, '0);
    do_load(16'h0000);
    frame(OFF, OFF, OFF, S7, 4'b0001, 1'b1, 1'b0, '0);
    frame(OFF, OFF, OFF, S0, 4'b0001, 1'b0, 1'b0, '0);
    blank_lz_i = 1'b0;

    // no ticks: hold digit 0; blank-time tick is ignored
    repeat (10) @(negedge clk);
    bad = 0;
    repeat (200) @(negedge clk) begin
      if (an_o !== 4'b1110 || seg_o !== S0) bad++;
    end
    chk("hold_digit0", 32'(bad), 0);
    slot(4'b1110, S0, 1'b0, 1'b0, 1'b0, '0);
    @(posedge clk); #1;
    tick_i = 1'b1;
    @(posedge clk); #1;
    tick_i = 1'b0;
    slot(4'b1101, S0, 1'b0, 1'b0, 1'b0, '0);
    slot(4'b1011, S0, 1'b0, 1'b0, 1'b0, '0);
    slot(4'b0111, S0, 1'b1, 1'b0, 1'b0, '0);

    repeat (5) @(posedge clk);
    chk("slot_q_left", 32'(exp_slot.size()), 0);
    chk("frame_q_left", 32'(exp_frame.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
